mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 62 ++++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared parameters/types plus the request/response bundle between the two
// cache ports, the arbiter and the memory side.
package params_pkg;
   localparam int ADDR_WIDTH = 32;
   typedef logic [1:0] access_size_t;
endpackage

interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = 128
);
   logic                       ic_req_valid_i;
   logic                       ic_req_ready_o;
   logic [ADDR_WIDTH-1:0]      ic_addr_i;
   params_pkg::access_size_t   ic_access_size_i;
   logic                       ic_rsp_valid_o;
   logic [DATA_WIDTH-1:0]      ic_rsp_data_o;

   logic                       dc_req_valid_i;
   logic                       dc_req_ready_o;
   logic                       dc_req_wr_i;
   logic [ADDR_WIDTH-1:0]      dc_addr_i;
   logic [DATA_WIDTH-1:0]      dc_wr_data_i;
   params_pkg::access_size_t   dc_access_size_i;
   logic                       dc_rsp_valid_o;
   logic [DATA_WIDTH-1:0]      dc_rsp_data_o;
   logic                       dc_wr_done_o;

   logic                       mem_rd_req_valid_o;
   logic                       mem_wr_req_valid_o;
   logic                       mem_req_is_instr_o;
   logic [ADDR_WIDTH-1:0]      mem_address_o;
   logic [DATA_WIDTH-1:0]      mem_wr_data_o;
   params_pkg::access_size_t   mem_access_size_o;
   logic                       mem_data_valid_i;
   logic                       mem_data_is_instr_i;
   logic [DATA_WIDTH-1:0]      mem_data_i;

   logic                       err_timeout_o;

   modport slave (
      input  ic_req_valid_i, ic_addr_i, ic_access_size_i,
      output ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
      input  dc_req_valid_i, dc_req_wr_i, dc_addr_i, dc_wr_data_i, dc_access_size_i,
      output dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o, dc_wr_done_o,
      output mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
      output mem_address_o, mem_wr_data_o, mem_access_size_o,
      input  mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
      output err_timeout_o
   );

   modport master (
      output ic_req_valid_i, ic_addr_i, ic_access_size_i,
      input  ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
      output dc_req_valid_i, dc_req_wr_i, dc_addr_i, dc_wr_data_i, dc_access_size_i,
      input  dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o, dc_wr_done_o,
      input  mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
      input  mem_address_o, mem_wr_data_o, mem_access_size_o,
      output mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
      input  err_timeout_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction and data cache ports onto a single
// memory channel, one outstanding transaction, with a read watchdog.
module mem_arbiter #(
   parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = 128,
   parameter int WR_LATENCY = 5,
   parameter int RD_TIMEOUT = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.slave  bus
);
   localparam int CNT_MAX = (WR_LATENCY > RD_TIMEOUT) ? WR_LATENCY : RD_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] WAIT_RD = 3'd2;
   localparam logic [2:0] WAIT_WR = 3'd3;
   localparam logic [2:0] RESP    = 3'd4;

   logic [2:0]               state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic                     last_dc_q;
   logic                     src_ic_q;
   logic                     wr_q;
   logic                     to_q;
   logic [ADDR_WIDTH-1:0]    addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   params_pkg::access_size_t size_q;
   logic [DATA_WIDTH-1:0]    ic_rdata_q;
   logic [DATA_WIDTH-1:0]    dc_rdata_q;

   logic gnt_ic, gnt_dc, in_idle, ic_acc, dc_acc, rd_match;

   // On a tie the port that did not win last time gets the grant.
   assign gnt_ic   = bus.ic_req_valid_i && (!bus.dc_req_valid_i || last_dc_q);
   assign gnt_dc   = bus.dc_req_valid_i && !gnt_ic;
   assign in_idle  = rst_i && (state_q == IDLE);
   assign ic_acc   = in_idle && gnt_ic;
   assign dc_acc   = in_idle && gnt_dc;
   assign rd_match = (state_q == WAIT_RD) && bus.mem_data_valid_i &&
                     (bus.mem_data_is_instr_i == src_ic_q);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_dc_q  <= 1'b1;
         src_ic_q   <= 1'b0;
         wr_q       <= 1'b0;
         to_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ic_acc || dc_acc) begin
                  src_ic_q  <= ic_acc;
                  last_dc_q <= dc_acc;
                  wr_q      <= dc_acc && bus.dc_req_wr_i;
                  to_q      <= 1'b0;
                  addr_q    <= ic_acc ? bus.ic_addr_i : bus.dc_addr_i;
                  size_q    <= ic_acc ? bus.ic_access_size_i : bus.dc_access_size_i;
                  if (dc_acc) wdata_q <= bus.dc_wr_data_i;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= wr_q ? WAIT_WR : WAIT_RD;
            end
            WAIT_RD: begin
               cnt_q <= cnt_q + 1'b1;
               if (rd_match) begin
                  if (src_ic_q) ic_rdata_q <= bus.mem_data_i;
                  else          dc_rdata_q <= bus.mem_data_i;
                  state_q <= RESP;
               end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                  // Watchdog expiry reuses RESP to emit the error pulse instead of a response.
                  to_q    <= 1'b1;
                  state_q <= RESP;
               end
            end
            WAIT_WR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WR_LATENCY - 1)) state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ic_req_ready_o     = ic_acc;
   assign bus.dc_req_ready_o     = dc_acc;

   assign bus.mem_rd_req_valid_o = (state_q == ISSUE) && !wr_q;
   assign bus.mem_wr_req_valid_o = (state_q == ISSUE) && wr_q;
   assign bus.mem_req_is_instr_o = src_ic_q;
   assign bus.mem_address_o      = addr_q;
   assign bus.mem_wr_data_o      = wdata_q;
   assign bus.mem_access_size_o  = size_q;

   assign bus.ic_rsp_valid_o     = (state_q == RESP) && src_ic_q && !wr_q && !to_q;
   assign bus.dc_rsp_valid_o     = (state_q == RESP) && !src_ic_q && !wr_q && !to_q;
   assign bus.dc_wr_done_o       = (state_q == RESP) && wr_q;
   assign bus.err_timeout_o      = (state_q == RESP) && to_q;
   assign bus.ic_rsp_data_o      = ic_rdata_q;
   assign bus.dc_rsp_data_o      = dc_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, hand sequences for
// arbitration/reset corners, and a randomized run against a transaction model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 128;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_LATENCY(5), .RD_TIMEOUT(16))
      dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   int checks = 0;
   int fails  = 0;

   typedef struct {
      bit          is_ic;
      bit          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int          lat;       // memory return at accept+1+lat, 0 = never
      bit          mism;      // wrong-source return one cycle before the real one
      int          exp_kind;  // 1 ic_rsp, 2 dc_rsp, 3 wr_done, 4 timeout
      int          exp_k;
      logic [DW-1:0] exp_data;
   } vec_t;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic samp();
      @(negedge clk_i);
   endtask

   task automatic quiet();
      bus.ic_req_valid_i = 0; bus.dc_req_valid_i = 0; bus.dc_req_wr_i = 0;
      bus.mem_data_valid_i = 0; bus.mem_data_is_instr_i = 0;
   endtask

   task automatic do_reset();
      quiet();
      rst_i = 0;
      repeat (2) step();
      @(negedge clk_i); rst_i = 1;
   endtask

   function automatic logic [3:0] pulses();
      return {bus.ic_rsp_valid_o, bus.dc_rsp_valid_o, bus.dc_wr_done_o, bus.err_timeout_o};
   endfunction

   task automatic run_txn(input vec_t v, output int mreq_k, output int ev_k,
                          output int ev_kind, output int nev, output logic [DW-1:0] ev_data);
      mreq_k = -1; ev_k = -1; ev_kind = 0; nev = 0; ev_data = '0;
      step();
      if (v.is_ic) begin
         bus.ic_req_valid_i = 1; bus.ic_addr_i = v.addr; bus.ic_access_size_i = 2'd3;
      end else begin
         bus.dc_req_valid_i = 1; bus.dc_addr_i = v.addr; bus.dc_req_wr_i = v.wr;
         bus.dc_wr_data_i = v.data; bus.dc_access_size_i = 2'd2;
      end
      samp();
      chk("vec_ready", {bus.ic_req_ready_o, bus.dc_req_ready_o}, v.is_ic ? 2'b10 : 2'b01);
      for (int k = 1; k <= 22; k++) begin
         step();
         bus.ic_req_valid_i = 0; bus.dc_req_valid_i = 0; bus.mem_data_valid_i = 0;
         if (v.lat != 0 && k == v.lat + 1) begin
            bus.mem_data_valid_i = 1; bus.mem_data_is_instr_i = v.is_ic; bus.mem_data_i = v.data;
         end else if (v.mism && k == v.lat) begin
            bus.mem_data_valid_i = 1; bus.mem_data_is_instr_i = !v.is_ic; bus.mem_data_i = ~v.data;
         end
         samp();
         if ((bus.mem_rd_req_valid_o || bus.mem_wr_req_valid_o) && mreq_k < 0) begin
            mreq_k = k;
            chk("vec_mem_addr", bus.mem_address_o, v.addr);
            chk("vec_mem_kind", {bus.mem_req_is_instr_o, bus.mem_wr_req_valid_o}, {v.is_ic, v.wr});
            if (v.wr) chk("vec_mem_wdata", bus.mem_wr_data_o, v.data);
         end
         nev += $countones(pulses());
         if (pulses() != 0 && ev_k < 0) begin
            ev_k = k;
            ev_kind = bus.ic_rsp_valid_o ? 1 : bus.dc_rsp_valid_o ? 2 : bus.dc_wr_done_o ? 3 : 4;
            ev_data = v.is_ic ? bus.ic_rsp_data_o : bus.dc_rsp_data_o;
         end
      end
      bus.mem_data_valid_i = 0;
   endtask

   vec_t vecs[8];
   logic [DW-1:0] d0123, dAA, d1, d2;

   // randomized-phase model state
   int free_at, acc, ret;
   bit has, last_ic, c_ic, c_wr, c_ok;
   logic [DW-1:0] c_rdat, c_wdata, ic_d, dc_d;
   logic [AW-1:0] m_addr;
   logic [1:0]    m_size;
   bit            m_instr;

   initial begin
      int mk, ek, kind, nev;
      logic [DW-1:0] edata;
      d0123 = {2{64'h0123_4567_89AB_CDEF}};
      dAA   = {16{8'hAA}};
      d1    = {4{32'h1111_2222}};
      d2    = {4{32'h3333_4444}};
      vecs[0] = '{1, 0, 32'h40,  d0123, 10, 0, 1, 12, d0123};
      vecs[1] = '{0, 1, 32'h80,  dAA,    0, 0, 3,  7, '0};
      vecs[2] = '{0, 0, 32'h100, d1,     3, 0, 2,  5, d1};
      vecs[3] = '{0, 0, 32'h140, d2,     0, 0, 4, 18, '0};
      vecs[4] = '{1, 0, 32'h180, d2,     5, 1, 1,  7, d2};
      vecs[5] = '{0, 0, 32'h1C0, d0123, 16, 0, 2, 18, d0123};
      vecs[6] = '{1, 0, 32'h200, d1,     1, 0, 1,  3, d1};
      vecs[7] = '{1, 0, 32'h240, dAA,   17, 0, 4, 18, '0};

      // Reset state with both requesters already asserting
      quiet();
      bus.ic_addr_i = 32'h10; bus.ic_access_size_i = 0;
      bus.dc_addr_i = 32'h20; bus.dc_access_size_i = 0; bus.dc_wr_data_i = '0; bus.mem_data_i = '0;
      bus.ic_req_valid_i = 1; bus.dc_req_valid_i = 1;
      samp();
      chk("reset_ready", {bus.ic_req_ready_o, bus.dc_req_ready_o}, 2'b00);
      chk("reset_valids", {bus.mem_rd_req_valid_o, bus.mem_wr_req_valid_o, pulses()}, '0);
      chk("reset_data", bus.ic_rsp_data_o | bus.dc_rsp_data_o | bus.mem_wr_data_o, '0);
      chk("reset_addr", {bus.mem_address_o, bus.mem_access_size_o, bus.mem_req_is_instr_o}, '0);
      rst_i = 1; #1;
      chk("tie1_ic_wins", {bus.ic_req_ready_o, bus.dc_req_ready_o}, 2'b10);
      step(); samp();
      chk("tie1_issue", {bus.mem_rd_req_valid_o, bus.mem_req_is_instr_o, bus.mem_address_o}, {2'b11, 32'h10});
      step(); bus.mem_data_valid_i = 1; bus.mem_data_is_instr_i = 1; bus.mem_data_i = d1;
      step(); bus.mem_data_valid_i = 0; samp();
      chk("tie1_ic_rsp", {bus.ic_rsp_valid_o, bus.dc_req_ready_o}, 2'b10);
      chk("tie1_ic_data", bus.ic_rsp_data_o, d1);
      step(); samp();
      chk("tie2_dc_wins", {bus.ic_req_ready_o, bus.dc_req_ready_o}, 2'b01);
      step(); bus.dc_req_valid_i = 0; samp();
      chk("tie2_issue", {bus.mem_rd_req_valid_o, bus.mem_req_is_instr_o, bus.mem_address_o}, {2'b10, 32'h20});
      step(); bus.mem_data_valid_i = 1; bus.mem_data_is_instr_i = 0; bus.mem_data_i = d2;
      step(); bus.mem_data_valid_i = 0; samp();
      chk("tie2_dc_rsp", {bus.dc_rsp_valid_o, bus.ic_rsp_valid_o}, 2'b10);
      chk("tie2_dc_data", bus.dc_rsp_data_o, d2);
      step(); bus.dc_req_valid_i = 1; samp();
      chk("tie3_ic_wins", {bus.ic_req_ready_o, bus.dc_req_ready_o}, 2'b10);

      // Reset in WAIT_RD, memory answers after release
      do_reset();
      step(); bus.dc_req_valid_i = 1; bus.dc_req_wr_i = 0; bus.dc_addr_i = 32'h300;
      samp(); chk("rst_mid_accept", bus.dc_req_ready_o, 1'b1);
      step(); bus.dc_req_valid_i = 0;
      step(); #2 rst_i = 0; #1;
      chk("rst_mid_async", {bus.mem_rd_req_valid_o, bus.mem_req_is_instr_o, pulses(), bus.mem_address_o}, '0);
      @(negedge clk_i); rst_i = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         bus.mem_data_valid_i = (i < 2); bus.mem_data_is_instr_i = i[0]; bus.mem_data_i = d0123;
         samp();
         chk("rst_mid_quiet", {bus.mem_rd_req_valid_o, bus.mem_wr_req_valid_o, pulses(),
                               bus.mem_address_o, bus.dc_rsp_data_o[31:0], bus.ic_rsp_data_o[31:0]}, '0);
      end
      bus.mem_data_valid_i = 0;

      // Directed vectors
      foreach (vecs[i]) begin
         run_txn(vecs[i], mk, ek, kind, nev, edata);
         chk("vec_memreq_cycle", mk, 1);
         chk("vec_event_kind", kind, vecs[i].exp_kind);
         chk("vec_event_cycle", ek, vecs[i].exp_k);
         chk("vec_event_count", nev, 1);
         if (vecs[i].exp_kind <= 2) chk("vec_rsp_data", edata, vecs[i].exp_data);
      end

      // Randomized traffic against a transaction-level model
      do_reset();
      free_at = 0; has = 0; last_ic = 0; acc = 0; ret = -100;
      c_ic = 0; c_wr = 0; c_ok = 0; c_rdat = '0; c_wdata = '0;
      ic_d = '0; dc_d = '0; m_addr = '0; m_size = '0; m_instr = 0;
      for (int c = 0; c < 1500; c++) begin
         bit idle, g_ic, g_dc, e_rd, e_wr, e_icr, e_dcr, e_done, e_to, waiting;
         int lat;
         step();
         bus.ic_req_valid_i = $urandom % 2; bus.ic_addr_i = $urandom; bus.ic_access_size_i = 2'($urandom);
         bus.dc_req_valid_i = $urandom % 2; bus.dc_addr_i = $urandom; bus.dc_access_size_i = 2'($urandom);
         bus.dc_req_wr_i = $urandom % 2; bus.dc_wr_data_i = {$urandom, $urandom, $urandom, $urandom};
         bus.mem_data_valid_i = 0;
         if (has && !c_wr && c == ret) begin
            bus.mem_data_valid_i = 1; bus.mem_data_is_instr_i = c_ic; bus.mem_data_i = c_rdat;
         end else if ($urandom % 6 == 0) begin
            waiting = has && !c_wr && c >= acc + 2 && c <= acc + 17;
            bus.mem_data_valid_i = 1;
            bus.mem_data_is_instr_i = waiting ? !c_ic : 1'($urandom);
            bus.mem_data_i = {$urandom, $urandom, $urandom, $urandom};
         end
         idle   = c >= free_at;
         g_ic   = idle && bus.ic_req_valid_i && (!bus.dc_req_valid_i || !last_ic);
         g_dc   = idle && bus.dc_req_valid_i && (!bus.ic_req_valid_i || last_ic);
         e_rd   = has && !c_wr && c == acc + 1;
         e_wr   = has && c_wr && c == acc + 1;
         e_icr  = has && !c_wr && c_ok && c_ic && c == ret + 1;
         e_dcr  = has && !c_wr && c_ok && !c_ic && c == ret + 1;
         e_done = has && c_wr && c == acc + 7;
         e_to   = has && !c_wr && !c_ok && c == acc + 18;
         if (e_icr) ic_d = c_rdat;
         if (e_dcr) dc_d = c_rdat;
         samp();
         chk("rnd_ready", {bus.ic_req_ready_o, bus.dc_req_ready_o}, {g_ic, g_dc});
         chk("rnd_mem_valid", {bus.mem_rd_req_valid_o, bus.mem_wr_req_valid_o}, {e_rd, e_wr});
         chk("rnd_pulses", pulses(), {e_icr, e_dcr, e_done, e_to});
         chk("rnd_ic_data", bus.ic_rsp_data_o, ic_d);
         chk("rnd_dc_data", bus.dc_rsp_data_o, dc_d);
         chk("rnd_mem_hold", {bus.mem_req_is_instr_o, bus.mem_access_size_o, bus.mem_address_o},
             {m_instr, m_size, m_addr});
         if (e_wr) chk("rnd_mem_wdata", bus.mem_wr_data_o, c_wdata);
         if (g_ic || g_dc) begin
            has = 1; acc = c; c_ic = g_ic; last_ic = g_ic;
            c_wr = g_dc && bus.dc_req_wr_i;
            m_instr = g_ic;
            m_addr  = g_ic ? bus.ic_addr_i : bus.dc_addr_i;
            m_size  = g_ic ? bus.ic_access_size_i : bus.dc_access_size_i;
            c_wdata = bus.dc_wr_data_i;
            c_rdat  = {$urandom, $urandom, $urandom, $urandom};
            lat = ($urandom % 6 == 0) ? 0 : $urandom_range(1, 18);
            c_ok = lat != 0 && lat <= 16;
            ret  = (lat == 0) ? -100 : acc + 1 + lat;
            free_at = c_wr ? acc + 8 : (c_ok ? ret + 2 : acc + 19);
         end
      end
      quiet();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
